// File: rtl/snn_pkg.sv
// Shared constants and types for the SNN input path and classifier core.
package snn_pkg;

  localparam int IMG_BITS = 784;
  localparam int DIGIT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    WAIT_BYTE,
    START,
    WAIT_DONE
  } loader_state_t;

endpackage

// File: rtl/snn_byte_unpacker.sv
// Serialises received bytes LSB-first, with a one-entry hold register that
// absorbs a byte arriving while the previous one is still being unpacked.
module snn_byte_unpacker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_rdy,
  input  logic       load_en,
  input  logic       drop_en,
  input  logic       clr_ovr,
  input  logic       img_end,
  output logic       bit_out,
  output logic       bit_vld,
  output logic       byte_last,
  output logic       hold_vld,
  output logic       overrun
);

  logic [7:0] shift_q;
  logic [7:0] hold_q;
  logic [2:0] bit_cnt;
  logic       busy;

  assign bit_out   = shift_q[0];
  assign bit_vld   = busy;
  assign byte_last = busy && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      hold_q   <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      hold_vld <= 1'b0;
      overrun  <= 1'b0;
    end else if (busy) begin
      shift_q <= shift_q >> 1;
      bit_cnt <= bit_cnt + 3'd1;
      if (bit_cnt == 3'd7) begin
        if (img_end) begin
          // Anything pending when the image completes has nowhere to go.
          busy     <= 1'b0;
          hold_vld <= 1'b0;
          if (hold_vld || rx_rdy) overrun <= 1'b1;
        end else if (hold_vld) begin
          shift_q  <= hold_q;
          hold_vld <= 1'b0;
          if (rx_rdy) overrun <= 1'b1;
        end else if (rx_rdy) begin
          // Byte lands in the empty hold slot and is consumed the same edge,
          // so it goes straight to the shifter with no gap cycle.
          shift_q <= rx_data;
        end else begin
          busy <= 1'b0;
        end
      end else if (rx_rdy) begin
        if (hold_vld) begin
          overrun <= 1'b1;
        end else begin
          hold_q   <= rx_data;
          hold_vld <= 1'b1;
        end
      end
    end else if (rx_rdy) begin
      if (load_en) begin
        shift_q <= rx_data;
        bit_cnt <= '0;
        busy    <= 1'b1;
        if (clr_ovr) overrun <= 1'b0;
      end else if (drop_en) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/snn_input_loader.sv
// Loads one image into the 1-bit input RAM from the UART byte stream, then
// hands off to snn_core and captures its classification.
module snn_input_loader #(
  parameter int IMG_BITS   = snn_pkg::IMG_BITS,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_rdy,
  input  logic                         core_done,
  input  logic [snn_pkg::DIGIT_W-1:0]  core_digit,
  output logic [ADDR_WIDTH-1:0]        ram_addr,
  output logic                         ram_data,
  output logic                         ram_we,
  output logic                         load_active,
  output logic                         core_start,
  output logic [snn_pkg::DIGIT_W-1:0]  digit,
  output logic                         digit_vld,
  output logic                         overrun
);

  import snn_pkg::*;

  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(IMG_BITS - 1);

  loader_state_t         state;
  logic [ADDR_WIDTH:0]   addr_cnt;
  logic                  bit_out;
  logic                  bit_vld;
  logic                  byte_last;
  logic                  hold_vld;
  logic                  img_end;
  logic                  load_en;
  logic                  drop_en;
  logic                  clr_ovr;

  assign img_end     = (addr_cnt == LAST_ADDR);
  assign load_en     = (state == IDLE) || (state == WAIT_BYTE);
  assign drop_en     = (state == START) || (state == WAIT_DONE);
  assign clr_ovr     = (state == IDLE);
  assign load_active = load_en || (state == UNPACK);
  assign ram_addr    = addr_cnt[ADDR_WIDTH-1:0];
  assign ram_data    = bit_out;
  assign ram_we      = bit_vld;

  snn_byte_unpacker u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_rdy    (rx_rdy),
    .load_en   (load_en),
    .drop_en   (drop_en),
    .clr_ovr   (clr_ovr),
    .img_end   (img_end),
    .bit_out   (bit_out),
    .bit_vld   (bit_vld),
    .byte_last (byte_last),
    .hold_vld  (hold_vld),
    .overrun   (overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_cnt   <= '0;
      core_start <= 1'b0;
      digit      <= '0;
      digit_vld  <= 1'b0;
    end else begin
      core_start <= 1'b0;
      digit_vld  <= 1'b0;
      case (state)
        IDLE: begin
          addr_cnt <= '0;
          if (rx_rdy) state <= UNPACK;
        end
        UNPACK: begin
          addr_cnt <= addr_cnt + 1'b1;
          if (byte_last) begin
            if (img_end) begin
              state      <= START;
              core_start <= 1'b1;
            end else if (!(hold_vld || rx_rdy)) begin
              state <= WAIT_BYTE;
            end
          end
        end
        WAIT_BYTE: begin
          if (rx_rdy) state <= UNPACK;
        end
        START: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (core_done) begin
            digit     <= core_digit;
            digit_vld <= 1'b1;
            addr_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/snn_input_loader.md
# snn_input_loader

Upstream feeder for `snn_core`. Receives image bytes from the UART receiver and unpacks each byte LSB-first into the 1-bit-wide, 1024-deep input RAM. After 784 bits (98 bytes), it pulses `start` to `snn_core`, waits for `done`, then captures the classified digit. It owns the input-RAM write port and signals the top level when it owns the RAM address bus.

## Interface
- `IMG_BITS`, default 784: pixels per image; must be a multiple of 8.
- `ADDR_WIDTH`, default 10: input RAM address width.
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `rx_data`, in, 8: received byte; valid only in the cycle `rx_rdy` is high.
- `rx_rdy`, in, 1: one-cycle pulse per received byte.
- `core_done`, in, 1: `snn_core` done.
- `core_digit`, in, 4: `snn_core` result.
- `ram_addr`, out, ADDR_WIDTH: input RAM write address.
- `ram_data`, out, 1: input RAM write data.
- `ram_we`, out, 1: input RAM write enable.
- `load_active`, out, 1: high while the loader owns the RAM address bus; the top level muxes `ram_addr` vs. `snn_core` `addr_input_unit` on it.
- `core_start`, out, 1: one-cycle start pulse to `snn_core`.
- `digit`, out, 4: last classified digit, held.
- `digit_vld`, out, 1: one-cycle pulse when `digit` updates.
- `overrun`, out, 1: sticky flag; a byte was dropped.

## Operation
- States:
  - IDLE: `addr_cnt` = 0. `rx_rdy` loads `rx_data` into the shift register → UNPACK.
  - UNPACK: each cycle `ram_we` = 1, `ram_data` = `shift[0]`, `ram_addr` = `addr_cnt`. Then shift right by 1 and increment `addr_cnt`. After the 8th bit:
    - if `addr_cnt` reaches IMG_BITS → START;
    - else if the hold register is valid → load the shift register from hold, clear hold, stay in UNPACK with no gap cycle;
    - else → WAIT_BYTE.
  - WAIT_BYTE: `rx_rdy` loads the shift register → UNPACK.
  - START: `core_start` = 1 for exactly this cycle → WAIT_DONE.
  - WAIT_DONE: on `core_done` = 1, register `core_digit` into `digit`, pulse `digit_vld`, clear `addr_cnt` → IDLE.
- Collisions:
  - `rx_rdy` during UNPACK goes into a one-entry hold register.
  - If hold is already full, the byte is dropped and `overrun` is set.
  - `rx_rdy` during START or WAIT_DONE: byte dropped, `overrun` set.
  - `rx_rdy` in the same cycle as the 8th-bit write with hold empty is accepted into hold.
- `overrun` clears only on the first byte accepted in IDLE, i.e. at the start of a new image.
- `load_active` is high in IDLE, UNPACK and WAIT_BYTE, and low in START and WAIT_DONE.
- Bit mapping: byte k, bit b → address 8k+b. Addresses IMG_BITS..1023 are never written.
- `addr_cnt` is ADDR_WIDTH+1 bits wide, so the compare against IMG_BITS never wraps.

## Timing
- Reset values: state IDLE.
  - 0: `ram_addr`, `ram_data`, `ram_we`, `core_start`, `digit_vld`, `overrun`, `addr_cnt`, hold-valid.
  - 1: `load_active`.
  - 0x0: `digit`.
- `rx_rdy` at edge n → first RAM write in cycle n+1. The byte's 8 writes occupy cycles n+1..n+8.
- Last write (addr IMG_BITS−1) in cycle m → `core_start` high in cycle m+1 → WAIT_DONE from m+2.
- `core_done` sampled high in cycle p → `digit` / `digit_vld` valid in cycle p+1. The loader accepts a new byte in cycle p+1.
- All outputs are driven from registered state, with no combinational path from `rx_*` or `core_*` to outputs.
- Reset asserted mid-load or mid-classify: the partial image is discarded, the next load restarts at address 0, and `digit` returns to 0.

## Structure
- Shared package `snn_pkg`:
  - `IMG_BITS` constant;
  - `loader_state_t` enum (IDLE, UNPACK, WAIT_BYTE, START, WAIT_DONE);
  - the digit width constant shared with `snn_core`.
- One sub-module: `snn_byte_unpacker`, holding the shift register, the 3-bit bit counter, the hold register and overrun logic. It emits `bit_out`, `bit_vld` and `byte_last`. The FSM and address counter stay in the top of `snn_input_loader`.

## Test plan
- Reset, then 98 bytes at 1 byte / 20 cycles from `ram_input_contents_sample_3` packing:
  - RAM contents match the sample file at addresses 0..783;
  - `core_start` pulses exactly once, one cycle after the write to addr 783.
- Byte 0xA5 as the first byte → writes 1,0,1,0,0,1,0,1 at addresses 0..7 in consecutive cycles, `ram_we` high for exactly 8 cycles.
- Two bytes `rx_rdy` one cycle apart → both unpacked back-to-back (16 consecutive write cycles), `overrun` stays 0. Three bytes in three consecutive cycles → third dropped, `overrun` = 1.
- Model `snn_core` returning digit 7 with `core_done` 500 cycles after start → `digit` = 7 and `digit_vld` one cycle. A byte sent during WAIT_DONE → dropped, `overrun` = 1. The next image clears it.
- `rst_n` low after 50 bytes → all outputs at reset values. A fresh 98-byte load restarts at addr 0 and completes normally.
